credit_ledger: RTL
==================

# credit_ledger

Credit bookkeeping stage that sits directly upstream of the five-digit seven-segment display multiplexer. It holds the player's credit balance as a 3-digit BCD counter (000–999) and the last win as a 2-digit BCD value (00–99), and presents them as the five BCD nibbles the display stage consumes. It accepts coin-insert, win-report and spin-request pulses from the game FSM, and arbitrates bet debits against the balance. It counts payouts up one credit at a time.

## Interface
Parameters:
- COIN_CREDITS, 1: credits added per coin_in pulse (1–15).
- BET_COST, 1: credits debited per granted spin (1–15).
- PAYOUT_DIV, 2000000: clocks per payout increment when PAYOUT_ANIM_EN is defined.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- coin_in  input  1  single-cycle pulse, one coin inserted (already debounced/synchronized)
- win_valid  input  1  single-cycle pulse, win_amt valid
- win_amt  input  7  binary win amount, values >99 clamp to 99
- spin_req  input  1  single-cycle pulse, player requests a spin
- spin_grant  output  1  one-cycle pulse, bet debited, spin may start
- spin_deny  output  1  one-cycle pulse, spin refused
- busy  output  1  high when not IDLE or pend_add ≠ 0
- won_amt1  output  4  win tens digit (BCD)
- won_amt2  output  4  win ones digit (BCD)
- credit_amt1  output  4  credit hundreds digit (BCD)
- credit_amt2  output  4  credit tens digit (BCD)
- credit_amt3  output  4  credit ones digit (BCD)

## Operation
- States: IDLE, PAYOUT, DEBIT. Internal 8-bit pend_add (credits owed), 4-bit debit count.
- Reset: state IDLE, credits 000, won 00, pend_add 0, spin_grant/spin_deny/busy 0.
- coin_in (any state): pend_add += COIN_CREDITS, saturating at 255.
- win_valid (any state): pend_add += min(win_amt,99), saturating at 255. The won digits load the BCD of min(win_amt,99).
- Simultaneous coin_in and win_valid: both amounts are added in the same cycle.
- IDLE → PAYOUT when pend_add ≠ 0.
- PAYOUT: on each increment tick, BCD credits +1 with ones→tens→hundreds carry, and pend_add −1. Return to IDLE when pend_add reaches 0.
- Credits at 999: further increments are discarded, but pend_add still drains to 0.
- spin_req in IDLE, pend_add = 0, no coin_in/win_valid that cycle, credits ≥ BET_COST: enter DEBIT. BCD credits −1 per clock with borrow, BET_COST times. Then return to IDLE with spin_grant. Won digits clear to 00 on grant.
- spin_req with credits < BET_COST, or in PAYOUT/DEBIT, or pend_add ≠ 0, or coincident with coin_in/win_valid: spin_deny. Nothing else changes.
- Credits never underflow below 000 or exceed 999. BCD digits are always 0–9.

## Timing
- All outputs are registered. Digit outputs update on the clock edge that applies an increment or decrement.
- spin_req sampled at edge N, spin granted:
  - credits decrement at edges N+1…N+BET_COST.
  - spin_grant is high for exactly the cycle after edge N+BET_COST.
  - busy is high from after edge N through edge N+BET_COST.
- spin_req sampled at edge N, spin denied: spin_deny is high for exactly the cycle after edge N.
- Payout with pend_add = P and PAYOUT_ANIM_EN undefined:
  - first increment at the edge after PAYOUT entry, then one per clock.
  - IDLE again P+1 edges after pend_add first becomes nonzero.
- busy deasserts on the same edge the state returns to IDLE with pend_add = 0.
- Reset asserted mid-PAYOUT or mid-DEBIT:
  - immediate return to reset values.
  - owed credits are lost.
  - no grant is issued.

## Configuration
- PAYOUT_ANIM_EN defined: a prescaler counts to PAYOUT_DIV−1. PAYOUT applies one increment per prescaler wrap, so the display visibly counts up. The prescaler resets to 0 on PAYOUT entry.
- PAYOUT_ANIM_EN undefined: no prescaler. PAYOUT applies one increment every clock. PAYOUT_DIV is unused.
- DEBIT timing is identical in both builds.

## Test plan
- Reset, then 3 coin_in pulses 5 cycles apart (COIN_CREDITS=1, no anim) → credits 003, busy low after the last payout, won 00.
- win_valid with win_amt=42 at credits 003 → won_amt1=4, won_amt2=2. Credits step 004…045, one per clock through the 009→010 and 039→040 carries. busy is high for 43 cycles.
- spin_req at credits 010 with BET_COST=3 → credits 009, 008, 007 on consecutive edges. spin_grant is high one cycle after the third decrement. Won clears to 00.
- spin_req at credits 002 with BET_COST=3 → spin_deny one cycle, credits stay 002. A second spin_req during PAYOUT → spin_deny.
- Saturation: credits 995, win_valid with win_amt=120 → won 99, credits stop at 999. pend_add drains to 0 and busy drops after 100 payout cycles.
- Assert reset_n low mid-PAYOUT (pend_add=20) → all outputs are reset values immediately. After release, no further increments occur.

Source files
------------

// File: rtl/credit_ledger.sv
// Credit balance (3-digit BCD) and last-win (2-digit BCD) bookkeeping ahead of the display mux.
// Optional build macro PAYOUT_ANIM_EN slows payout to one credit per PAYOUT_DIV clocks.
module credit_ledger #(
   parameter int unsigned COIN_CREDITS = 1,
   parameter int unsigned BET_COST     = 1,
   parameter int unsigned PAYOUT_DIV   = 2000000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       coin_in,
   input  logic       win_valid,
   input  logic [6:0] win_amt,
   input  logic       spin_req,
   output logic       spin_grant,
   output logic       spin_deny,
   output logic       busy,
   output logic [3:0] won_amt1,
   output logic [3:0] won_amt2,
   output logic [3:0] credit_amt1,
   output logic [3:0] credit_amt2,
   output logic [3:0] credit_amt3
);

   localparam int unsigned SUM_W  = 10;
   localparam int unsigned PEND_W = 8;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] PAYOUT = 2'd1;
   localparam logic [1:0] DEBIT  = 2'd2;

   if (COIN_CREDITS < 1 || COIN_CREDITS > 15 || BET_COST < 1 || BET_COST > 15 || PAYOUT_DIV < 1)
   begin : g_bad_param
      $error("credit_ledger: parameter out of range");
   end

   logic [1:0]        state_q, state_d;
   logic [PEND_W-1:0] pend_q, pend_d;
   logic [3:0]        dcnt_q, dcnt_d;
   logic [3:0]        c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;
   logic [3:0]        w1_q, w1_d, w2_q, w2_d;
   logic              grant_q, grant_d, deny_q, deny_d, busy_q, busy_d;

   logic              tick_c;
   logic [6:0]        win_clamp_c;
   logic [SUM_W-1:0]  add_c, sum_c, cred_bin_c;
   logic              pay_c, can_spin_c;

`ifdef PAYOUT_ANIM_EN
   localparam int unsigned PRE_W = (PAYOUT_DIV > 1) ? $clog2(PAYOUT_DIV) : 1;
   logic [PRE_W-1:0] pre_q, pre_d;

   assign tick_c = (pre_q == PRE_W'(PAYOUT_DIV - 1));

   // Prescaler only runs in PAYOUT, so it restarts from 0 on every entry
   always_comb begin
      pre_d = '0;
      if (state_q == PAYOUT && !tick_c) pre_d = pre_q + PRE_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) pre_q <= '0;
      else          pre_q <= pre_d;
   end
`else
   assign tick_c = 1'b1;
`endif

   // Pending-credit arithmetic shared by all states
   always_comb begin
      win_clamp_c = (win_amt > 7'd99) ? 7'd99 : win_amt;
      add_c       = (coin_in   ? SUM_W'(COIN_CREDITS) : '0)
                  + (win_valid ? SUM_W'(win_clamp_c)  : '0);
      pay_c       = (state_q == PAYOUT) && tick_c && (pend_q != '0);
      sum_c       = SUM_W'(pend_q) - SUM_W'(pay_c) + add_c;
      pend_d      = (sum_c > SUM_W'(255)) ? PEND_W'(255) : sum_c[PEND_W-1:0];
      cred_bin_c  = SUM_W'(c1_q) * SUM_W'(100) + SUM_W'(c2_q) * SUM_W'(10) + SUM_W'(c3_q);
      can_spin_c  = (state_q == IDLE) && (pend_q == '0) && !coin_in && !win_valid
                  && (cred_bin_c >= SUM_W'(BET_COST));
   end

   always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      c1_d    = c1_q;
      c2_d    = c2_q;
      c3_d    = c3_q;
      w1_d    = w1_q;
      w2_d    = w2_q;
      grant_d = 1'b0;
      deny_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (pend_q != '0) state_d = PAYOUT;
            if (spin_req) begin
               if (can_spin_c) begin
                  state_d = DEBIT;
                  dcnt_d  = 4'(BET_COST);
               end else begin
                  deny_d = 1'b1;
               end
            end
         end
         PAYOUT: begin
            deny_d = spin_req;
            // Increments past 999 are dropped while pend_add keeps draining
            if (pay_c && cred_bin_c != SUM_W'(999)) begin
               if (c3_q != 4'd9) c3_d = c3_q + 4'd1;
               else begin
                  c3_d = 4'd0;
                  if (c2_q != 4'd9) c2_d = c2_q + 4'd1;
                  else begin
                     c2_d = 4'd0;
                     c1_d = c1_q + 4'd1;
                  end
               end
            end
            if (pend_d == '0) state_d = IDLE;
         end
         DEBIT: begin
            deny_d = spin_req;
            if (cred_bin_c != '0) begin
               if (c3_q != 4'd0) c3_d = c3_q - 4'd1;
               else begin
                  c3_d = 4'd9;
                  if (c2_q != 4'd0) c2_d = c2_q - 4'd1;
                  else begin
                     c2_d = 4'd9;
                     c1_d = c1_q - 4'd1;
                  end
               end
            end
            dcnt_d = dcnt_q - 4'd1;
            if (dcnt_q == 4'd1) begin
               state_d = IDLE;
               grant_d = 1'b1;
               w1_d    = 4'd0;
               w2_d    = 4'd0;
            end
         end
         default: state_d = IDLE;
      endcase

      // A fresh win report overrides the clear-on-grant
      if (win_valid) begin
         w1_d = 4'(win_clamp_c / 7'd10);
         w2_d = 4'(win_clamp_c % 7'd10);
      end

      busy_d = (state_d != IDLE) || (pend_d != '0);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         pend_q  <= '0;
         dcnt_q  <= '0;
         c1_q    <= '0;
         c2_q    <= '0;
         c3_q    <= '0;
         w1_q    <= '0;
         w2_q    <= '0;
         grant_q <= 1'b0;
         deny_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         dcnt_q  <= dcnt_d;
         c1_q    <= c1_d;
         c2_q    <= c2_d;
         c3_q    <= c3_d;
         w1_q    <= w1_d;
         w2_q    <= w2_d;
         grant_q <= grant_d;
         deny_q  <= deny_d;
         busy_q  <= busy_d;
      end
   end

   assign spin_grant  = grant_q;
   assign spin_deny   = deny_q;
   assign busy        = busy_q;
   assign won_amt1    = w1_q;
   assign won_amt2    = w2_q;
   assign credit_amt1 = c1_q;
   assign credit_amt2 = c2_q;
   assign credit_amt3 = c3_q;

endmodule
